inv_shift_rows_ser: RTL

INV_SHIFT_ROWS_SER -- requirements
Module: inv_shift_rows_ser

---
 rtl/inv_shift_rows_ser_if.sv | 40 ++++
 rtl/inv_shift_rows_ser.sv | 124 ++++++++++++
 2 files changed

// File: rtl/inv_shift_rows_ser_if.sv
// ---------------------------------------------------------------------------
// inv_shift_rows_ser_if
// Bundle of the byte-in / block-out handshake used by inv_shift_rows_ser.
//
// Signals:
//   in_valid   qualifies in_byte / in_sof
//   in_byte    8-bit ciphertext-state byte, column-major order
//   in_sof     marks byte 0 of a block
//   in_ready   the block can take a byte this cycle
//   out_valid  out_state holds a complete block
//   out_state  128-bit block after InvShiftRows, byte i at [127-8i -: 8]
//   out_ready  downstream accepts out_state
//   err_resync one-cycle pulse when a partial block is aborted by in_sof
//   blk_cnt    wrapping count of delivered blocks
//
// Modports:
//   master  the side that produces bytes and consumes blocks
//   slave   the inv_shift_rows_ser block itself
// ---------------------------------------------------------------------------
interface inv_shift_rows_ser_if;
    logic         in_valid;
    logic [7:0]   in_byte;
    logic         in_sof;
    logic         in_ready;
    logic         out_valid;
    logic [127:0] out_state;
    logic         out_ready;
    logic         err_resync;
    logic [7:0]   blk_cnt;

    modport master (
        output in_valid, in_byte, in_sof, out_ready,
        input  in_ready, out_valid, out_state, err_resync, blk_cnt
    );

    modport slave (
        input  in_valid, in_byte, in_sof, out_ready,
        output in_ready, out_valid, out_state, err_resync, blk_cnt
    );
endinterface

// File: rtl/inv_shift_rows_ser.sv
// ---------------------------------------------------------------------------
// inv_shift_rows_ser
// Serial-in AES-128 InvShiftRows. Bytes arrive one per cycle in column-major
// order and are scattered straight into their inverse-permuted slot of a
// 128-bit buffer, so the block is ready one cycle after its 16th byte with
// no separate permutation pass.
//
// Ports:
//   clk   single rising-edge clock
//   rst   synchronous active-high reset
//   bus   inv_shift_rows_ser_if.slave (byte input, block output, status)
// ---------------------------------------------------------------------------
module inv_shift_rows_ser (
    input  logic                  clk,
    input  logic                  rst,
    inv_shift_rows_ser_if.slave   bus
);

    typedef enum logic {
        LOAD = 1'b0,
        FULL = 1'b1
    } state_t;

    state_t       state;
    state_t       state_nx;
    logic [3:0]   cnt;
    logic [3:0]   cnt_nx;
    logic [127:0] buffer;
    logic [7:0]   blk_cnt_q;
    logic         err_q;
    logic         err_nx;
    logic         accept;
    logic         drain;
    logic         wr_en;
    logic [3:0]   wr_idx;
    logic [3:0]   wr_slot;

    // Input byte index (row r = idx[1:0], column c = idx[3:2]) lands in
    // output column (c + r) mod 4 of the same row; the 2-bit add wraps for us.
    function automatic logic [3:0] dest_index(input logic [3:0] idx);
        logic [1:0] row;
        logic [1:0] col;
        row = idx[1:0];
        col = idx[3:2] + row;
        return {col, row};
    endfunction

    // In FULL the ready is passed through from downstream so a new byte can
    // be taken in the same cycle the finished block drains.
    assign bus.in_ready   = !rst && ((state == LOAD) || bus.out_ready);
    assign bus.out_valid  = !rst && (state == FULL);
    assign bus.out_state  = buffer;
    assign bus.err_resync = err_q;
    assign bus.blk_cnt    = blk_cnt_q;

    assign accept  = bus.in_valid && bus.in_ready;
    assign wr_slot = dest_index(wr_idx);

    // Next-state logic. An accepted in_sof always restarts at byte 0; if it
    // cuts a partial block short the resync error is raised for one cycle.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        err_nx   = 1'b0;
        wr_en    = 1'b0;
        wr_idx   = cnt;
        drain    = 1'b0;
        case (state)
            LOAD: begin
                if (accept) begin
                    wr_en = 1'b1;
                    if (bus.in_sof) begin
                        wr_idx = 4'd0;
                        cnt_nx = 4'd1;
                        err_nx = (cnt != 4'd0);
                    end else if (cnt == 4'd15) begin
                        state_nx = FULL;
                        cnt_nx   = 4'd0;
                    end else begin
                        cnt_nx = cnt + 4'd1;
                    end
                end
            end
            FULL: begin
                if (bus.out_ready) begin
                    drain    = 1'b1;
                    state_nx = LOAD;
                    if (accept) begin
                        wr_en  = 1'b1;
                        wr_idx = 4'd0;
                        cnt_nx = 4'd1;
                    end
                end
            end
            default: begin
                state_nx = LOAD;
            end
        endcase
    end

    // State, counters and the scatter buffer. Slot o sits at bits
    // [127-8o -: 8], i.e. base 8*(15-o), which is just {~o, 3'b000}.
    // Unwritten slots keep stale data; it is hidden while in LOAD.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= LOAD;
            cnt       <= 4'd0;
            err_q     <= 1'b0;
            blk_cnt_q <= 8'd0;
            buffer    <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            err_q <= err_nx;
            if (drain) begin
                blk_cnt_q <= blk_cnt_q + 8'd1;
            end
            if (wr_en) begin
                buffer[{~wr_slot, 3'b000} +: 8] <= bus.in_byte;
            end
        end
    end

endmodule
